uart_debug_bridge: RTL and testbench
====================================

Name: uart_debug_bridge

Overview:
- Command/response engine between the UART FIFO interface (r_data/rd/rx_empty, w_data/wr/tx_full) and the MIPS_DLX core enable.
- Decodes single-byte host commands to run, stop or single-step the core, and streams a snapshot of the PC plus NUM_WORDS debug words back over UART.
- Parametrised successor to the fixed 10-bit PC / enable-only hookup: generic PC width, word width and debug channel count, with an explicit step mode and ACK/NAK replies.

Parameters:
PC_WIDTH, 10, width of pc input (PC_plus_1 of core)
WORD_WIDTH, 32, width of each debug word
NUM_WORDS, 4, number of debug channels packed in debug_data

Ports:
clock  input  1  system clock (core clock domain)
reset  input  1  asynchronous, active-low reset
r_data  input  8  RX FIFO head byte, valid when rx_empty=0 (first-word-fall-through)
rx_empty  input  1  RX FIFO empty
rd  output  1  RX FIFO pop
w_data  output  8  TX byte
wr  output  1  TX FIFO push
tx_full  input  1  TX FIFO full
pc  input  PC_WIDTH  current core PC
debug_data  input  NUM_WORDS*WORD_WIDTH  debug words, word 0 in LSBs
cpu_enable  output  1  core enable

Behaviour:
- Reset (reset=0, async): state=IDLE, run=0, step=0, wr=0, w_data=0x00, cpu_enable=0; snapshot and byte counter cleared; an in-progress dump or reply is aborted, with no further bytes written.
- rd is combinational: rd = (state==IDLE) & !rx_empty. The command is decoded from r_data in the same cycle t.
- Commands (constants): R=0x52 run, S=0x53 stop, T=0x54 step, D=0x44 dump. ACK=0x06, NAK=0x15, HDR=0xA5.
- R: run<=1 at t+1; reply ACK.
- S: run<=0 at t+1; reply ACK. S while already stopped also replies ACK.
- T while stopped: step=1 for exactly cycle t+1 only; reply ACK. T while running: no pulse, run unchanged; reply NAK.
- D: pc and debug_data captured at the edge ending cycle t. Stream = HDR, then PC_BYTES=ceil(PC_WIDTH/8) PC bytes, then per word 0..NUM_WORDS-1 WORD_BYTES=ceil(WORD_WIDTH/8) bytes. Multi-byte values are sent LSB first, with upper bits zero-padded. Total = 1+PC_BYTES+NUM_WORDS*WORD_BYTES. run is unaffected; the core may keep running during a dump.
- Any other byte: reply NAK.
- cpu_enable = run | step (registered sources, no combinational path from r_data).
- States:
  - IDLE: pops a command. Goes to REPLY (R/S/T/unknown) or SEND (D).
  - REPLY: wr=1 with the reply byte in the first cycle where tx_full=0, then IDLE.
  - SEND: one wr per cycle while tx_full=0. When tx_full=1, wr=0 and the counter holds. After the last byte, IDLE.
- wr is never asserted while tx_full=1. Earliest reply/header wr is at t+1. Minimum command-to-command spacing is 2 cycles (reply cycle, then IDLE).
- Bytes arriving while in REPLY/SEND stay in the RX FIFO (rd=0); no command is dropped.
- Counter sized $clog2(total+1). No wrap: the exit condition is count==total-1 with wr.

Decomposition:
- Package uart_dbg_pkg: command/reply constants (CMD_RUN, CMD_STOP, CMD_STEP, CMD_DUMP, ACK, NAK, HDR), state enum {IDLE, REPLY, SEND}, and a function computing byte counts from widths.
- Sub-module dbg_snapshot_shifter: loads the zero-padded {words, pc} image on capture and shifts out 8 bits per accepted wr, LSB first.
- The top FSM owns the rd/wr handshakes, run/step and the reply mux.

Test Plan:
- Reset, then push 0x52 -> rd high 1 cycle; ACK 0x06 written at t+1; cpu_enable=1 from t+1. Then 0x53 -> ACK; cpu_enable=0.
- Stopped, push 0x54 -> cpu_enable high exactly 1 cycle; ACK written. While running, push 0x54 -> NAK 0x15; cpu_enable stays 1.
- pc=0x2A7, debug_data words {0x11223344, 0xAABBCCDD, 0, 0xFFFFFFFF}, push 0x44 -> 19 bytes: A5 A7 02 44 33 22 11 DD CC BB AA 00 00 00 00 FF FF FF FF.
- Dump with tx_full asserted for 3 cycles mid-stream -> wr low during stall; no byte lost or duplicated; order unchanged.
- Push 0x44,0x52 back-to-back -> second rd only after last dump byte; then ACK. Push 0x7A -> NAK.
- Assert reset after 5 dump bytes -> wr=0, cpu_enable=0 immediately; no further bytes; next command handled normally.

Source files
------------

// File: rtl/uart_dbg_pkg.sv
// ============================================================================
// Module   : uart_dbg_pkg
// Purpose  : Command/reply bytes, FSM states and byte-count helper for the
//            UART debug bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_dbg_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STOP = 8'h53;
    localparam logic [7:0] CMD_STEP = 8'h54;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;
    localparam logic [7:0] HDR      = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REPLY = 2'd1,
        SEND  = 2'd2
    } state_e;

    function automatic int unsigned bytes_for(input int unsigned bits);
        return (bits + 32'd7) / 32'd8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dbg_snapshot_shifter.sv
// ============================================================================
// Module   : dbg_snapshot_shifter
// Purpose  : Captures {header, pc, words} as a zero-padded byte image and
//            shifts it out one byte per accepted write, LSB first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dbg_snapshot_shifter
    import uart_dbg_pkg::*;
#(
    parameter int PC_WIDTH   = 10,
    parameter int WORD_WIDTH = 32,
    parameter int NUM_WORDS  = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            load_i,
    input  logic                            shift_i,
    input  logic [PC_WIDTH-1:0]             pc_i,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] data_i,
    output logic [7:0]                      byte_o
);

    localparam int PC_BYTES   = int'(bytes_for(PC_WIDTH));
    localparam int WORD_BYTES = int'(bytes_for(WORD_WIDTH));
    localparam int TOTAL      = 1 + PC_BYTES + NUM_WORDS * WORD_BYTES;
    localparam int IMG_W      = 8 * TOTAL;
    localparam int WORD_BASE  = 8 + 8 * PC_BYTES;

    logic [IMG_W-1:0] img_q;
    logic [IMG_W-1:0] w_image;

    // Each field starts on a byte boundary; padding bits stay zero.
    always_comb begin
        w_image               = '0;
        w_image[7:0]          = HDR;
        w_image[8 +: PC_WIDTH] = pc_i;
        for (int i = 0; i < NUM_WORDS; i++) begin
            w_image[WORD_BASE + i*8*WORD_BYTES +: WORD_WIDTH] =
                data_i[i*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            img_q <= '0;
        end else if (load_i) begin
            img_q <= w_image;
        end else if (shift_i) begin
            img_q <= {8'h00, img_q[IMG_W-1:8]};
        end
    end

    assign byte_o = img_q[7:0];

endmodule

`default_nettype wire

// File: rtl/uart_debug_bridge.sv
// ============================================================================
// Module   : uart_debug_bridge
// Purpose  : Host command engine: run/stop/step the core and stream a PC plus
//            debug-word snapshot back over the UART FIFOs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_debug_bridge
    import uart_dbg_pkg::*;
#(
    parameter int PC_WIDTH   = 10,
    parameter int WORD_WIDTH = 32,
    parameter int NUM_WORDS  = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [7:0]                      r_data,
    input  logic                            rx_empty,
    output logic                            rd,
    output logic [7:0]                      w_data,
    output logic                            wr,
    input  logic                            tx_full,
    input  logic [PC_WIDTH-1:0]             pc,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] debug_data,
    output logic                            cpu_enable
);

    localparam int PC_BYTES   = int'(bytes_for(PC_WIDTH));
    localparam int WORD_BYTES = int'(bytes_for(WORD_WIDTH));
    localparam int TOTAL      = 1 + PC_BYTES + NUM_WORDS * WORD_BYTES;
    localparam int CNT_W      = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    state_e           state_q, state_d;
    logic             run_q, run_d;
    logic             step_q, step_d;
    logic [7:0]       reply_q, reply_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_load;
    logic             w_shift;
    logic [7:0]       w_snap_byte;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            step_q  <= 1'b0;
            reply_q <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            step_q  <= step_d;
            reply_q <= reply_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        step_d  = 1'b0;
        reply_d = reply_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rd) begin
                    state_d = REPLY;
                    case (r_data)
                        CMD_RUN: begin
                            run_d   = 1'b1;
                            reply_d = ACK;
                        end
                        CMD_STOP: begin
                            run_d   = 1'b0;
                            reply_d = ACK;
                        end
                        CMD_STEP: begin
                            // A step only makes sense while halted.
                            step_d  = !run_q;
                            reply_d = run_q ? NAK : ACK;
                        end
                        CMD_DUMP: begin
                            state_d = SEND;
                            cnt_d   = '0;
                        end
                        default: reply_d = NAK;
                    endcase
                end
            end
            REPLY: begin
                if (wr) begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (wr) begin
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd         = (state_q == IDLE) && !rx_empty;
        wr         = ((state_q == REPLY) || (state_q == SEND)) && !tx_full;
        w_load     = rd && (r_data == CMD_DUMP);
        w_shift    = (state_q == SEND) && wr;
        cpu_enable = run_q | step_q;
        case (state_q)
            REPLY:   w_data = reply_q;
            SEND:    w_data = w_snap_byte;
            default: w_data = 8'h00;
        endcase
    end

    dbg_snapshot_shifter #(
        .PC_WIDTH   (PC_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .NUM_WORDS  (NUM_WORDS)
    ) u_snapshot (
        .clock   (clock),
        .reset   (reset),
        .load_i  (w_load),
        .shift_i (w_shift),
        .pc_i    (pc),
        .data_i  (debug_data),
        .byte_o  (w_snap_byte)
    );

endmodule

`default_nettype wire

// File: tb/tb_uart_debug_bridge.sv
// ============================================================================
// Module   : tb_uart_debug_bridge
// Purpose  : Self-checking bench: RX FIFO model, byte-stream/enable reference
//            model checked every cycle, plus literal expected streams.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_debug_bridge;

    localparam int PC_WIDTH   = 10;
    localparam int WORD_WIDTH = 32;
    localparam int NUM_WORDS  = 4;
    localparam int PCB        = (PC_WIDTH + 7) / 8;
    localparam int WB         = (WORD_WIDTH + 7) / 8;

    logic                            clock;
    logic                            reset;
    logic [7:0]                      r_data;
    logic                            rx_empty;
    logic                            rd;
    logic [7:0]                      w_data;
    logic                            wr;
    logic                            tx_full;
    logic [PC_WIDTH-1:0]             pc;
    logic [NUM_WORDS*WORD_WIDTH-1:0] debug_data;
    logic                            cpu_enable;

    uart_debug_bridge #(
        .PC_WIDTH   (PC_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .NUM_WORDS  (NUM_WORDS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .r_data     (r_data),
        .rx_empty   (rx_empty),
        .rd         (rd),
        .w_data     (w_data),
        .wr         (wr),
        .tx_full    (tx_full),
        .pc         (pc),
        .debug_data (debug_data),
        .cpu_enable (cpu_enable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [7:0] fifo[$];
    logic [7:0] expq[$];
    logic [7:0] log_q[$];
    bit         run_m  = 1'b0;
    bit         exp_en = 1'b0;
    bit         pop_req = 1'b0;
    int         en_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic upd_fifo();
        rx_empty = (fifo.size() == 0);
        r_data   = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        upd_fifo();
    endtask

    always @(posedge clock) begin
        #1;
        if (pop_req && fifo.size() != 0) begin
            void'(fifo.pop_front());
            upd_fifo();
        end
    end

    // Reference model: a command consumed at cycle t queues its reply bytes,
    // which the DUT must emit in order on every non-full cycle that follows.
    always @(negedge clock) begin
        bit         exp_rd, exp_wr, next_en;
        logic [63:0] v;
        if (!reset) begin
            chk("wr_in_reset", wr, 1'b0);
            chk("en_in_reset", cpu_enable, 1'b0);
            expq.delete();
            run_m   = 1'b0;
            exp_en  = 1'b0;
            pop_req = 1'b0;
        end else begin
            exp_rd = (expq.size() == 0) && (fifo.size() != 0);
            exp_wr = (expq.size() != 0) && !tx_full;
            chk("rd", rd, exp_rd);
            chk("wr", wr, exp_wr);
            chk("cpu_enable", cpu_enable, exp_en);
            if (cpu_enable) en_cnt++;
            if (wr) log_q.push_back(w_data);
            if (exp_wr && wr) begin
                chk("w_data", w_data, expq[0]);
                void'(expq.pop_front());
            end
            next_en = run_m;
            if (exp_rd) begin
                case (fifo[0])
                    8'h52: begin run_m = 1'b1; next_en = 1'b1; expq.push_back(8'h06); end
                    8'h53: begin run_m = 1'b0; next_en = 1'b0; expq.push_back(8'h06); end
                    8'h54: begin
                        if (run_m) expq.push_back(8'h15);
                        else begin next_en = 1'b1; expq.push_back(8'h06); end
                    end
                    8'h44: begin
                        expq.push_back(8'hA5);
                        v = 64'(pc);
                        for (int k = 0; k < PCB; k++) expq.push_back(8'((v >> (8*k)) & 64'hFF));
                        for (int w = 0; w < NUM_WORDS; w++) begin
                            v = 64'(debug_data[w*WORD_WIDTH +: WORD_WIDTH]);
                            for (int k = 0; k < WB; k++) expq.push_back(8'((v >> (8*k)) & 64'hFF));
                        end
                    end
                    default: expq.push_back(8'h15);
                endcase
            end
            exp_en  = next_en;
            pop_req = rd;
        end
    end

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((fifo.size() != 0 || expq.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, 64'(n >= 200), 64'd0);
        tick();
    endtask

    task automatic wait_bytes(input int cnt);
        int n;
        n = 0;
        while (log_q.size() < cnt && n < 200) begin
            tick();
            n++;
        end
        chk("wait_bytes_timeout", 64'(n >= 200), 64'd0);
    endtask

    task automatic check_log(input string nm, input logic [7:0] exp[$]);
        chk({nm, "_len"}, 64'(log_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            chk($sformatf("%s_byte%0d", nm, i), log_q[i], exp[i]);
        log_q.delete();
    endtask

    logic [7:0] dump_exp[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dump_exp = '{8'hA5, 8'hA7, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11,
                     8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'hFF, 8'hFF, 8'hFF, 8'hFF};
        reset      = 1'b0;
        tx_full    = 1'b0;
        pc         = '0;
        debug_data = '0;
        upd_fifo();
        repeat (3) tick();
        chk("reset_wr", wr, 1'b0);
        chk("reset_wdata", w_data, 8'h00);
        chk("reset_en", cpu_enable, 1'b0);
        reset = 1'b1;
        tick();
        chk("idle_rd", rd, 1'b0);

        // Run, then stop
        push(8'h52); wait_idle("run");
        check_log("run", '{8'h06});
        chk("run_en", cpu_enable, 1'b1);
        push(8'h53); wait_idle("stop");
        check_log("stop", '{8'h06});
        chk("stop_en", cpu_enable, 1'b0);

        // Single step while halted, then step rejected while running
        en_cnt = 0;
        push(8'h54); wait_idle("step");
        check_log("step", '{8'h06});
        chk("step_pulse_len", 64'(en_cnt), 64'd1);
        push(8'h52); wait_idle("run2");
        push(8'h54); wait_idle("step_nak");
        check_log("step_nak", '{8'h06, 8'h15});
        chk("step_nak_en", cpu_enable, 1'b1);
        push(8'h53); wait_idle("stop2");
        log_q.delete();

        // Snapshot dump
        pc         = 10'h2A7;
        debug_data = {32'hFFFFFFFF, 32'h00000000, 32'hAABBCCDD, 32'h11223344};
        push(8'h44); wait_idle("dump");
        check_log("dump", dump_exp);

        // Dump with a 3-cycle TX stall mid-stream
        push(8'h44);
        wait_bytes(6);
        tx_full = 1'b1;
        repeat (3) tick();
        tx_full = 1'b0;
        wait_idle("dump_stall");
        check_log("dump_stall", dump_exp);

        // Back-to-back dump then run, then an unknown command
        push(8'h44); push(8'h52); wait_idle("dump_run");
        begin
            logic [7:0] e[$];
            e = dump_exp;
            e.push_back(8'h06);
            check_log("dump_run", e);
        end
        push(8'h7A); wait_idle("unknown");
        check_log("unknown", '{8'h15});

        // Reset in the middle of a dump while running
        push(8'h44);
        wait_bytes(5);
        reset = 1'b0;
        fifo.delete();
        upd_fifo();
        #1;
        chk("abort_wr", wr, 1'b0);
        chk("abort_en", cpu_enable, 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("abort_bytes", 64'(log_q.size()), 64'd5);
        log_q.delete();
        push(8'h52); wait_idle("after_abort");
        check_log("after_abort", '{8'h06});
        chk("after_abort_en", cpu_enable, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
